div_reconstruct_seq: RTL and testbench

//   Sequential inverse of the combinational divide/modulo path. Rebuilds the

---
 rtl/div_reconstruct_seq.sv | 129 ++++++++++++
 tb/tb_div_reconstruct_seq.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/div_reconstruct_seq.sv
// Rebuilds numerator = quotient*divisor + remainder with a shift-add multiplier,
// flagging zero divisors and out-of-range remainders.
module div_reconstruct_seq #(
  parameter int QW = 16,
  parameter int DW = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [QW-1:0]      quotient,
  input  logic [DW-1:0]      divisor,
  input  logic [DW-1:0]      remainder,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [QW+DW-1:0]   numerator,
  output logic               div_zero,
  output logic               rem_err
);

  localparam int AW = QW + DW;
  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [AW-1:0]   mcand_q, mcand_d;
  logic [DW-1:0]   mplier_q, mplier_d;
  logic [AW-1:0]   numerator_q, numerator_d;
  logic            div_zero_q, div_zero_d;
  logic            rem_err_q, rem_err_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    numerator_d = numerator_q;
    div_zero_d  = div_zero_q;
    rem_err_d   = rem_err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d    = MUL;
          count_d    = {CW{1'b0}};
          acc_d      = {{QW{1'b0}}, remainder};
          mcand_d    = {{DW{1'b0}}, quotient};
          mplier_d   = divisor;
          div_zero_d = (divisor == {DW{1'b0}});
          rem_err_d  = (divisor != {DW{1'b0}}) && (remainder >= divisor);
        end else begin
          state_d = IDLE;
        end
      end
      MUL: begin
        // DW add cycles then one publish cycle: count==DW means all bits consumed.
        if (count_q == CW'(DW)) begin
          state_d     = DONE;
          numerator_d = acc_q;
        end else begin
          if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
          end else begin
            acc_d = acc_q;
          end
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          count_d  = count_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State and datapath registers; reset abandons any job in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= {CW{1'b0}};
      acc_q       <= {AW{1'b0}};
      mcand_q     <= {AW{1'b0}};
      mplier_q    <= {DW{1'b0}};
      numerator_q <= {AW{1'b0}};
      div_zero_q  <= 1'b0;
      rem_err_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      numerator_q <= numerator_d;
      div_zero_q  <= div_zero_d;
      rem_err_q   <= rem_err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign numerator = numerator_q;
  assign div_zero  = div_zero_q;
  assign rem_err   = rem_err_q;

endmodule

// File: tb/tb_div_reconstruct_seq.sv
// Randomized bench for div_reconstruct_seq: expected results come from plain
// arithmetic q*d+r kept in a queue of outstanding jobs.
module tb_div_reconstruct_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] quotient;
  logic [7:0]  divisor;
  logic [7:0]  remainder;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] numerator;
  logic        div_zero;
  logic        rem_err;

  div_reconstruct_seq #(.QW(16), .DW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .quotient(quotient), .divisor(divisor), .remainder(remainder),
    .out_valid(out_valid), .out_ready(out_ready),
    .numerator(numerator), .div_zero(div_zero), .rem_err(rem_err)
  );

  typedef struct {
    logic [23:0] num;
    logic        dz;
    logic        re;
    int          acc_cyc;
    bit          has_lit;
    logic [23:0] lit;
  } exp_t;

  exp_t expq[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   or_mode  = 1;   // 0: hold low, 1: always high, 2: random
  logic prev_ov  = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // out_ready driver
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (or_mode == 0)      out_ready = 1'b0;
      else if (or_mode == 1) out_ready = 1'b1;
      else                   out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Compare process: handshake model and result check every cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, (expq.size() == 0)});
      if (out_valid) begin
        if (expq.size() == 0) begin
          chk("spurious_out_valid", 32'd1, 32'd0);
        end else begin
          if (!prev_ov) chk("latency", cyc - expq[0].acc_cyc, 32'd9);
          chk("numerator", {8'd0, numerator}, {8'd0, expq[0].num});
          chk("div_zero", {31'd0, div_zero}, {31'd0, expq[0].dz});
          chk("rem_err", {31'd0, rem_err}, {31'd0, expq[0].re});
          if (expq[0].has_lit) chk("numerator_lit", {8'd0, numerator}, {8'd0, expq[0].lit});
          if (out_ready) void'(expq.pop_front());
        end
      end else if (expq.size() != 0 && cyc >= expq[0].acc_cyc + 9) begin
        chk("late_out_valid", 32'd0, 32'd1);
      end
      prev_ov <= out_valid;
    end else begin
      prev_ov <= 1'b0;
    end
  end

  task automatic send(input logic [15:0] q, input logic [7:0] d, input logic [7:0] r,
                      input bit lit_en, input logic [23:0] lit);
    exp_t e;
    int   n;
    @(posedge clk);
    #1;
    in_valid  = 1'b1;
    quotient  = q;
    divisor   = d;
    remainder = r;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      e.num     = 24'(32'(q) * 32'(d) + 32'(r));
      e.dz      = (d == 8'd0);
      e.re      = (d != 8'd0) && (r >= d);
      e.acc_cyc = cyc + 1;
      e.has_lit = lit_en;
      e.lit     = lit;
      expq.push_back(e);
      #1;
      in_valid  = 1'b0;
      quotient  = 16'($urandom);
      divisor   = 8'($urandom);
      remainder = 8'($urandom);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expq.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain", expq.size(), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_numerator"}, {8'd0, numerator}, 32'd0);
    chk({tag, "_div_zero"}, {31'd0, div_zero}, 32'd0);
    chk({tag, "_rem_err"}, {31'd0, rem_err}, 32'd0);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] q;
    logic [7:0]  d;
    logic [7:0]  r;
    int          n;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    quotient  = 16'd0;
    divisor   = 8'd0;
    remainder = 8'd0;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;

    // Directed cases with hand-computed results.
    or_mode = 1;
    send(16'h1234, 8'h56, 8'h12, 1'b1, 24'h061D8A); drain();
    send(16'hFFFF, 8'hFF, 8'hFE, 1'b1, 24'hFEFFFF); drain();
    send(16'hFFFF, 8'h00, 8'hFF, 1'b1, 24'h0000FF); drain();
    send(16'h0003, 8'h05, 8'h07, 1'b1, 24'h000016); drain();

    // Result held in DONE while new input is offered.
    or_mode = 0;
    send(16'hBEEF, 8'h3C, 8'h11, 1'b0, 24'd0);
    fork
      send(16'h0102, 8'h03, 8'h01, 1'b0, 24'd0);
      begin
        n = 0;
        while (!out_valid && n < 100) begin
          @(negedge clk);
          n++;
        end
        repeat (5) @(posedge clk);
        or_mode = 1;
      end
    join
    drain();

    // Reset in the middle of a multiply.
    send(16'h4321, 8'hA5, 8'h09, 1'b0, 24'd0);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    expq.delete();
    #1 check_reset_outputs("midreset");
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("heldreset");
    #2 rst_n = 1'b1;
    send(16'h0ABC, 8'h21, 8'h20, 1'b0, 24'd0); drain();

    // Randomized jobs with random back-pressure.
    for (int i = 0; i < 40; i++) begin
      q = 16'($urandom);
      d = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      r = ($urandom_range(0, 3) == 0) ? 8'($urandom) : ((d == 8'd0) ? 8'd0 : 8'($urandom_range(0, 32'(d) - 1)));
      or_mode = ($urandom_range(0, 1) == 0) ? 1 : 2;
      send(q, d, r, 1'b0, 24'd0);
    end
    or_mode = 1;
    drain();

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
